// File: rtl/fdc_pkg.sv
// -----------------------------------------------------------------------------
// fdc_pkg
// Shared types and constants for the floppy-controller SD arbiter slice.
//   NUM_DRV     : number of drive channels (fixed at 4, index is 2 bits)
//   drv_idx_t   : drive index type
//   arb_state_t : arbiter FSM states
// -----------------------------------------------------------------------------
package fdc_pkg;

    localparam int NUM_DRV = 4;

    typedef logic [1:0] drv_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } arb_state_t;

endpackage : fdc_pkg

// File: rtl/fdc_rr_pick.sv
// -----------------------------------------------------------------------------
// fdc_rr_pick
// Combinational round-robin picker: returns the first set request found when
// scanning ptr, ptr+1, ... modulo NUM_DRV.
//   req   : per-drive request vector
//   ptr   : scan start index
//   valid : any request set
//   idx   : chosen drive index (equals ptr when nothing is requested)
// -----------------------------------------------------------------------------
module fdc_rr_pick
    import fdc_pkg::*;
(
    input  logic [NUM_DRV-1:0] req,
    input  drv_idx_t           ptr,
    output logic               valid,
    output drv_idx_t           idx
);

    drv_idx_t cand;

    // Scan from the farthest offset down to ptr itself so the nearest
    // requester (lowest offset) is the last, and therefore winning, write.
    always_comb begin
        valid = |req;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_DRV - 1; k >= 0; k--) begin
            cand = ptr + drv_idx_t'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule : fdc_rr_pick

// File: rtl/fdc_sd_arbiter.sv
// -----------------------------------------------------------------------------
// fdc_sd_arbiter
// Serialises the four per-drive SD sector requests of the floppy controller
// onto a single virtual-disk host port with round-robin fairness, routes the
// host ack and write-buffer byte to/from the granted drive, and flags request
// timeouts.
//
// Ports
//   CLK, RESET_N     : clock (rising edge), async active-low reset
//   drv_lba[4]       : per-drive sector LBA
//   drv_rd / drv_wr  : per-drive level requests, held until acked
//   drv_ack          : per-drive ack, host_ack gated to the granted drive
//   drv_buff_din[4]  : per-drive write-buffer byte
//   img_mounted      : mount pulses; abort a granted request still in REQ
//   host_lba/rd/wr   : request to the VD port
//   host_ack         : VD port ack
//   host_buff_din    : granted drive's buffer byte
//   host_drive       : granted drive index
//   busy             : arbiter not idle
//   err / err_drive  : sticky timeout flag and drive of the last timeout
// -----------------------------------------------------------------------------
module fdc_sd_arbiter
    import fdc_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [NUM_DRV-1:0][31:0]  drv_lba,
    input  logic [NUM_DRV-1:0]        drv_rd,
    input  logic [NUM_DRV-1:0]        drv_wr,
    output logic [NUM_DRV-1:0]        drv_ack,
    input  logic [NUM_DRV-1:0][7:0]   drv_buff_din,
    input  logic [NUM_DRV-1:0]        img_mounted,
    output logic [31:0]               host_lba,
    output logic                      host_rd,
    output logic                      host_wr,
    input  logic                      host_ack,
    output logic [7:0]                host_buff_din,
    output drv_idx_t                  host_drive,
    output logic                      busy,
    output logic                      err,
    output drv_idx_t                  err_drive
);

    localparam logic [23:0] TO_LAST = TIMEOUT - 24'd1;

    arb_state_t  state_q, state_d;
    drv_idx_t    rr_ptr_q, rr_ptr_d;
    drv_idx_t    grant_q, grant_d;
    logic [31:0] host_lba_q, host_lba_d;
    logic        op_wr_q, op_wr_d;
    logic [23:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    drv_idx_t    err_drive_q, err_drive_d;

    logic        pick_vld;
    drv_idx_t    pick_idx;
    logic        abort;
    logic        timed_out;

    fdc_rr_pick u_pick (
        .req   (drv_rd | drv_wr),
        .ptr   (rr_ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // A mount on the granted drive only matters while the request is pending;
    // once the host has acked, the transfer runs to completion.
    assign abort     = img_mounted[grant_q];
    assign timed_out = (cnt_q == TO_LAST);

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            host_lba_q  <= '0;
            op_wr_q     <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            err_drive_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            host_lba_q  <= host_lba_d;
            op_wr_q     <= op_wr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_drive_q <= err_drive_d;
        end
    end

    // Next-state logic. Within REQ an abort beats an ack, and an ack beats a
    // timeout landing on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_vld) state_d = ST_REQ;
            ST_REQ: begin
                if (abort)          state_d = ST_DONE;
                else if (host_ack)  state_d = ST_XFER;
                else if (timed_out) state_d = ST_DONE;
            end
            ST_XFER: if (!host_ack) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        host_lba_d  = host_lba_q;
        op_wr_d     = op_wr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        err_drive_d = err_drive_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d    = pick_idx;
                    host_lba_d = drv_lba[pick_idx];
                    // Read wins when a drive raises both.
                    op_wr_d    = ~drv_rd[pick_idx];
                    cnt_d      = '0;
                end
            end
            ST_REQ: begin
                if (cnt_q != 24'hFF_FFFF) cnt_d = cnt_q + 24'd1;
                if (!abort && !host_ack && timed_out) begin
                    err_d       = 1'b1;
                    err_drive_d = grant_q;
                end
            end
            ST_DONE: rr_ptr_d = grant_q + drv_idx_t'(1);
            default: ;
        endcase
    end

    // Outputs. Requests are a decode of the registered state so reset drops
    // them asynchronously; ack routing is a zero-latency gate.
    always_comb begin
        host_rd = 1'b0;
        host_wr = 1'b0;
        drv_ack = '0;
        if (state_q == ST_REQ) begin
            host_rd = ~op_wr_q;
            host_wr = op_wr_q;
        end
        if (host_ack && (state_q == ST_REQ || state_q == ST_XFER)) begin
            drv_ack[grant_q] = 1'b1;
        end
    end

    assign host_lba      = host_lba_q;
    assign host_drive    = grant_q;
    assign host_buff_din = drv_buff_din[grant_q];
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;
    assign err_drive     = err_drive_q;

endmodule : fdc_sd_arbiter

// File: tb/tb_fdc_sd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fdc_sd_arbiter
// Directed steps followed by randomized traffic, checked every cycle against a
// cycle-level reference model of the arbiter's rules.
// -----------------------------------------------------------------------------
module tb_fdc_sd_arbiter;

    localparam logic [23:0] TO = 24'd16;
    localparam int P_IDLE = 0, P_REQ = 1, P_XFER = 2, P_DONE = 3;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic [3:0][31:0] drv_lba;
    logic [3:0]       drv_rd, drv_wr, drv_ack, img_mounted;
    logic [3:0][7:0]  drv_buff_din;
    logic [31:0]      host_lba;
    logic             host_rd, host_wr, host_ack, busy, err;
    logic [7:0]       host_buff_din;
    logic [1:0]       host_drive, err_drive;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int          m_ph, m_grant, m_ptr, m_cnt, m_err_drv;
    logic [31:0] m_lba;
    bit          m_wr, m_err;

    fdc_sd_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .drv_lba(drv_lba), .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_ack(drv_ack),
        .drv_buff_din(drv_buff_din), .img_mounted(img_mounted),
        .host_lba(host_lba), .host_rd(host_rd), .host_wr(host_wr),
        .host_ack(host_ack), .host_buff_din(host_buff_din),
        .host_drive(host_drive), .busy(busy), .err(err), .err_drive(err_drive)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, expected finish before 1ms");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_grant = 0; m_ptr = 0; m_cnt = 0;
        m_err_drv = 0; m_lba = '0; m_wr = 0; m_err = 0;
    endtask

    // One clock of the arbiter rules, applied to the inputs present at the edge.
    task automatic model_step();
        logic [3:0] req;
        int j;
        req = drv_rd | drv_wr;
        case (m_ph)
            P_IDLE: begin
                if (req != 0) begin
                    for (int k = 3; k >= 0; k--) begin
                        j = (m_ptr + k) % 4;
                        if (req[j]) m_grant = j;
                    end
                    m_lba = drv_lba[m_grant];
                    m_wr  = !drv_rd[m_grant];
                    m_cnt = 0;
                    m_ph  = P_REQ;
                end
            end
            P_REQ: begin
                if (img_mounted[m_grant]) m_ph = P_DONE;
                else if (host_ack) m_ph = P_XFER;
                else if (m_cnt == int'(TO) - 1) begin
                    m_err = 1; m_err_drv = m_grant; m_ph = P_DONE;
                end
                m_cnt++;
            end
            P_XFER: if (!host_ack) m_ph = P_DONE;
            default: begin
                m_ptr = (m_grant + 1) % 4;
                m_ph  = P_IDLE;
            end
        endcase
    endtask

    task automatic check_all();
        logic [31:0] exp_ack;
        exp_ack = (host_ack && (m_ph == P_REQ || m_ph == P_XFER)) ? (32'd1 << m_grant) : 32'd0;
        chk("host_rd",       host_rd,       32'(m_ph == P_REQ && !m_wr));
        chk("host_wr",       host_wr,       32'(m_ph == P_REQ && m_wr));
        chk("host_lba",      host_lba,      m_lba);
        chk("host_drive",    host_drive,    32'(m_grant));
        chk("busy",          busy,          32'(m_ph != P_IDLE));
        chk("err",           err,           32'(m_err));
        chk("err_drive",     err_drive,     32'(m_err_drv));
        chk("drv_ack",       drv_ack,       exp_ack);
        chk("host_buff_din", host_buff_din, 32'(drv_buff_din[m_grant]));
    endtask

    // Inputs are set in the low phase; outputs checked, then the edge, then
    // back to the next falling edge.
    task automatic step();
        #1 check_all();
        @(posedge CLK);
        if (RESET_N) model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        #1;
        model_reset();
        check_all();
        drv_rd = '0; drv_wr = '0; host_ack = 1'b0; img_mounted = '0;
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        drv_rd = '0; drv_wr = '0; host_ack = 1'b0; img_mounted = '0;
        for (int i = 0; i < 4; i++) begin
            drv_lba[i] = $urandom;
            drv_buff_din[i] = 8'($urandom);
        end
        do_reset();

        // Single read on drive 2.
        drv_rd = 4'b0100; drv_lba[2] = 32'h123;
        step();
        chk("rd2_host_rd", host_rd, 1);
        chk("rd2_lba", host_lba, 32'h123);
        chk("rd2_drive", host_drive, 2);
        host_ack = 1'b1;
        #1 chk("rd2_ack_same_cycle", drv_ack, 4'b0100);
        step();
        chk("rd2_xfer_rd_low", host_rd, 0);
        drv_rd = '0; host_ack = 1'b0;
        step();
        step();
        // rr_ptr is now 3: with drives 0 and 3 requesting, 3 wins.
        drv_rd = 4'b1001;
        step();
        chk("rr_ptr_after_2", host_drive, 3);
        host_ack = 1'b1; step();
        host_ack = 1'b0; drv_rd = '0; step(); step(); step();

        // Read beats write on one drive.
        drv_rd = 4'b0010; drv_wr = 4'b0010;
        step();
        chk("prio_rd", host_rd, 1);
        chk("prio_wr", host_wr, 0);
        host_ack = 1'b1; drv_rd = '0; drv_wr = '0; step();
        host_ack = 1'b0; step(); step();

        // Write on drive 3: its buffer byte is forwarded throughout.
        drv_wr = 4'b1000; drv_buff_din[3] = 8'hA5;
        step();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 3; i++) drv_buff_din[i] = 8'($urandom);
            host_ack = (c >= 2 && c < 4);
            if (c == 2) drv_wr = '0;
            #1 chk("wr3_buff_din", host_buff_din, 8'hA5);
            step();
        end

        // Fairness: all four reading from rr_ptr=0 -> 0,1,2,3,0.
        do_reset();
        drv_rd = 4'b1111;
        step();
        for (int t = 0; t < 5; t++) begin
            for (int w = 0; w < 8 && host_rd !== 1'b1; w++) step();
            chk("fair_req_seen", host_rd, 1);
            chk("fair_order", host_drive, 32'(t % 4));
            host_ack = 1'b1; step();
            host_ack = 1'b0; step();
            step();
            step();
        end
        drv_rd = '0; step(); step(); step(); step();

        // Timeout on a drive-0 write with no host ack.
        do_reset();
        drv_wr = 4'b0001;
        step();
        for (int c = 0; c < int'(TO); c++) begin
            chk("to_wr_held", host_wr, 1);
            step();
        end
        chk("to_wr_dropped", host_wr, 0);
        chk("to_err", err, 1);
        chk("to_err_drive", err_drive, 0);
        drv_wr = '0;
        step();
        chk("to_idle", busy, 0);
        chk("to_err_sticky", err, 1);

        // Mount abort while drive 1 waits in REQ.
        do_reset();
        drv_rd = 4'b0010;
        step();
        chk("ab_req", host_rd, 1);
        img_mounted = 4'b0010;
        step();
        img_mounted = '0;
        chk("ab_rd_drop", host_rd, 0);
        chk("ab_no_err", err, 0);
        drv_rd = '0; step(); step();

        // Reset in the middle of a transfer.
        drv_rd = 4'b0001; drv_lba[0] = 32'hDEAD_BEEF;
        step();
        host_ack = 1'b1;
        step();
        chk("rst_in_xfer", busy, 1);
        RESET_N = 1'b0;
        #1;
        chk("rst_lba", host_lba, 0);
        chk("rst_ack", drv_ack, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3) == 0) host_ack = ~host_ack;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(9) == 0) begin
                    drv_rd[i]  = 1'($urandom_range(1));
                    drv_wr[i]  = 1'($urandom_range(1));
                    drv_lba[i] = $urandom;
                end
                img_mounted[i]  = ($urandom_range(49) == 0);
                drv_buff_din[i] = 8'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fdc_sd_arbiter
